// File: rtl/rst_sequencer.sv
// Reset sequencer: filters PLL lock, then releases domain resets in order,
// with runtime soft reset of a domain subset and re-sequencing on lock loss.
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst           asynchronous active-high reset
//   pll_lock      raw PLL lock (async), 2-flop synchronized
//   sw_rst_req    one-cycle soft-reset request, honoured only in RUN
//   sw_rst_mask   domains to soft-reset, sampled with sw_rst_req
//   lock_lost_clr clears the sticky lock_lost flag
//   rst_out       per-domain resets, active-high, registered
//   ready         all domains released and FSM in RUN
//   lock_lost     sticky: lock dropped after the first RUN
//   state         debug: 0=HOLD 1=REL 2=RUN 3=SOFT
module rst_sequencer #(
  parameter int N_DOMAINS   = 4,
  parameter int LOCK_FILT   = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_lock,
  input  logic                 sw_rst_req,
  input  logic [N_DOMAINS-1:0] sw_rst_mask,
  input  logic                 lock_lost_clr,
  output logic [N_DOMAINS-1:0] rst_out,
  output logic                 ready,
  output logic                 lock_lost,
  output logic [1:0]           state
);

  localparam int IW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [7:0] LF_MAX =
    8'(LOCK_FILT);
  localparam logic [7:0] GAP_LAST =
    8'(GAP_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST =
    8'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(N_DOMAINS - 1);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    REL  = 2'd1,
    RUN  = 2'd2,
    SOFT = 2'd3
  } state_t;

  logic sync1_q;
  logic sync2_q;
  logic lock_s;

  state_t               state_q, state_d;
  logic [7:0]           lock_cnt_q, lock_cnt_d;
  logic [7:0]           gap_cnt_q, gap_cnt_d;
  logic [7:0]           hold_cnt_q, hold_cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [N_DOMAINS-1:0] rel_set_q, rel_set_d;
  logic [N_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                 ready_q, ready_d;
  logic                 lost_q, lost_d;
  logic                 seen_run_q, seen_run_d;
  logic                 lost_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_lock;
      sync2_q <= sync1_q;
    end
  end

  assign lock_s = sync2_q;

  // Consecutive-lock filter, saturating
  always_comb begin
    lock_cnt_d = 8'd0;
    if (lock_s) begin
      if (lock_cnt_q == LF_MAX)
        lock_cnt_d = LF_MAX;
      else
        lock_cnt_d = lock_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    hold_cnt_d = hold_cnt_q;
    idx_d      = idx_q;
    rel_set_d  = rel_set_q;
    rst_out_d  = rst_out_q;
    ready_d    = ready_q;
    seen_run_d = seen_run_q;
    lost_set   = 1'b0;

    // Lock loss outranks every other transition
    if (state_q != HOLD && !lock_s) begin
      state_d    = HOLD;
      rst_out_d  = '1;
      ready_d    = 1'b0;
      idx_d      = '0;
      gap_cnt_d  = 8'd0;
      hold_cnt_d = 8'd0;
      lost_set   = (state_q != REL) ||
                   seen_run_q;
    end else begin
      unique case (state_q)
        HOLD: begin
          rst_out_d = '1;
          ready_d   = 1'b0;
          if (lock_cnt_q == LF_MAX) begin
            state_d   = REL;
            idx_d     = '0;
            gap_cnt_d = 8'd0;
            rel_set_d = '1;
          end
        end
        REL: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = 8'd0;
            idx_d     = idx_q + IW'(1);
            // Unselected slots still burn a full gap
            if (rel_set_q[idx_q])
              rst_out_d[idx_q] = 1'b0;
            if (idx_q == IDX_LAST) begin
              state_d    = RUN;
              ready_d    = 1'b1;
              seen_run_d = 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 8'd1;
          end
        end
        RUN: begin
          if (sw_rst_req && |sw_rst_mask) begin
            state_d    = SOFT;
            rst_out_d  = rst_out_q | sw_rst_mask;
            rel_set_d  = sw_rst_mask;
            ready_d    = 1'b0;
            hold_cnt_d = 8'd0;
          end
        end
        SOFT: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d   = REL;
            idx_d     = '0;
            gap_cnt_d = 8'd0;
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end
        default: state_d = HOLD;
      endcase
    end

    // Set beats clear when both land together
    if (lost_set)
      lost_d = 1'b1;
    else if (lock_lost_clr)
      lost_d = 1'b0;
    else
      lost_d = lost_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HOLD;
      lock_cnt_q <= 8'd0;
      gap_cnt_q  <= 8'd0;
      hold_cnt_q <= 8'd0;
      idx_q      <= '0;
      rel_set_q  <= '1;
      rst_out_q  <= '1;
      ready_q    <= 1'b0;
      lost_q     <= 1'b0;
      seen_run_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      idx_q      <= idx_d;
      rel_set_q  <= rel_set_d;
      rst_out_q  <= rst_out_d;
      ready_q    <= ready_d;
      lost_q     <= lost_d;
      seen_run_q <= seen_run_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign ready     = ready_q;
  assign lock_lost = lost_q;
  assign state     = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: phase/timestamp reference model plus
// directed timing points and a randomized soak.
module tb_rst_sequencer;

  localparam int N = 4;
  localparam int F = 16;
  localparam int G = 8;
  localparam int H = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         pll_lock;
  logic         sw_rst_req;
  logic [N-1:0] sw_rst_mask;
  logic         lock_lost_clr;
  logic [N-1:0] rst_out;
  logic         ready;
  logic         lock_lost;
  logic [1:0]   state;

  int checks   = 0;
  int failures = 0;

  // Model: current phase, the edge it began on, and the domain set
  int       cyc;
  int       m_mode;
  int       m_t0;
  int       m_lockcnt;
  logic [3:0] m_mask;
  bit       m_seen;
  bit       m_lost;
  bit       lq[$];

  rst_sequencer #(
    .N_DOMAINS(N),
    .LOCK_FILT(F),
    .GAP_CYCLES(G),
    .HOLD_CYCLES(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_lock(pll_lock),
    .sw_rst_req(sw_rst_req),
    .sw_rst_mask(sw_rst_mask),
    .lock_lost_clr(lock_lost_clr),
    .rst_out(rst_out),
    .ready(ready),
    .lock_lost(lock_lost),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    cyc       = 0;
    m_mode    = 0;
    m_t0      = 0;
    m_lockcnt = 0;
    m_mask    = 4'hF;
    m_seen    = 1'b0;
    m_lost    = 1'b0;
    lq        = '{1'b0, 1'b0};
  endtask

  task automatic model_edge(input bit lk, input bit rq,
                            input logic [3:0] mk,
                            input bit cl);
    bit ls;
    bit set;
    ls  = lq[0];
    void'(lq.pop_front());
    lq.push_back(lk);
    set = 1'b0;
    if (m_mode != 0 && !ls) begin
      set    = (m_mode != 1) || m_seen;
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (m_lockcnt == F) begin
          m_mode = 1; m_t0 = cyc; m_mask = 4'hF;
        end
        1: if (cyc - m_t0 == N * G) begin
          m_mode = 2; m_seen = 1'b1;
        end
        2: if (rq && mk != 4'h0) begin
          m_mode = 3; m_t0 = cyc; m_mask = mk;
        end
        default: if (cyc - m_t0 == H) begin
          m_mode = 1; m_t0 = cyc;
        end
      endcase
    end
    if (set) m_lost = 1'b1;
    else if (cl) m_lost = 1'b0;
    if (!ls) m_lockcnt = 0;
    else if (m_lockcnt < F) m_lockcnt++;
  endtask

  function automatic logic [7:0] exp_vec();
    logic [3:0] r;
    logic [4:0] low;
    int k;
    case (m_mode)
      0: r = 4'hF;
      1: begin
        k = (cyc - m_t0) / G;
        if (k > N) k = N;
        low = 5'((1 << k) - 1);
        r = m_mask & ~low[3:0];
      end
      2: r = 4'h0;
      default: r = m_mask;
    endcase
    return {r, m_mode == 2, 2'(m_mode), m_lost};
  endfunction

  // One clock edge: inputs sampled as driven before the edge
  task automatic step();
    bit lk, rq, cl, rs;
    logic [3:0] mk;
    lk = pll_lock; rq = sw_rst_req;
    cl = lock_lost_clr; mk = sw_rst_mask;
    rs = rst;
    @(posedge clk);
    if (rs) model_reset();
    else begin
      cyc++;
      model_edge(lk, rq, mk, cl);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pll_lock = 1'b0;
    sw_rst_req = 1'b0;
    lock_lost_clr = 1'b0;
    sw_rst_mask = 4'h0;
    #1;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if ({rst_out, ready, state, lock_lost} !== 8'b1111_0_00_0) begin
      failures++;
      $display("FAIL reset_vals got=%b exp=%b",
               {rst_out, ready, state, lock_lost}, 8'b1111_0_00_0);
    end
    checks++;
    for (int i = 0; i < 10; i++) begin
      step();
      if ({rst_out, ready, state, lock_lost} !== exp_vec()) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b",
                 cyc, {rst_out, ready, state, lock_lost}, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_power_up();
    logic [4:0] want;
    bit have;
    do_reset();
    pll_lock = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      step();
      if ({rst_out, ready, state, lock_lost} !== exp_vec()) begin
        failures++;
        $display("FAIL pwr_model e=%0d got=%b exp=%b",
                 e, {rst_out, ready, state, lock_lost}, exp_vec());
      end
      checks++;
      have = 1'b1;
      case (e)
        26: want = 5'b1111_0;
        27: want = 5'b1110_0;
        34: want = 5'b1110_0;
        35: want = 5'b1100_0;
        43: want = 5'b1000_0;
        50: want = 5'b1000_0;
        51: want = 5'b0000_1;
        default: begin want = 5'b0; have = 1'b0; end
      endcase
      if (have) begin
        if ({rst_out, ready} !== want) begin
          failures++;
          $display("FAIL pwr_edge e=%0d got=%b exp=%b",
                   e, {rst_out, ready}, want);
        end
        checks++;
      end
    end
  endtask

  task automatic test_lock_filter();
    do_reset();
    pll_lock = 1'b1;
    for (int i = 0; i < 10; i++) step();
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      step();
      if ({rst_out, ready, state, lock_lost} !== exp_vec()) begin
        failures++;
        $display("FAIL filt_model e=%0d got=%b exp=%b",
                 e, {rst_out, ready, state, lock_lost}, exp_vec());
      end
      checks++;
      if (e == 26 && rst_out !== 4'b1111) begin
        failures++;
        $display("FAIL filt_early got=%b exp=%b", rst_out, 4'b1111);
      end
      if (e == 26) checks++;
      if (e == 27 && rst_out !== 4'b1110) begin
        failures++;
        $display("FAIL filt_rel got=%b exp=%b", rst_out, 4'b1110);
      end
      if (e == 27) checks++;
    end
  endtask

  task automatic test_soft_reset();
    logic [6:0] want;
    bit have;
    do_reset();
    pll_lock = 1'b1;
    for (int i = 0; i < 55; i++) step();
    sw_rst_req = 1'b1;
    sw_rst_mask = 4'b0101;
    for (int s = 1; s <= 55; s++) begin
      step();
      sw_rst_req = 1'b0;
      sw_rst_mask = 4'($urandom);
      if ({rst_out, ready, state, lock_lost} !== exp_vec()) begin
        failures++;
        $display("FAIL soft_model s=%0d got=%b exp=%b",
                 s, {rst_out, ready, state, lock_lost}, exp_vec());
      end
      checks++;
      have = 1'b1;
      case (s)
        1:  want = 7'b0101_0_11;
        16: want = 7'b0101_0_11;
        17: want = 7'b0101_0_01;
        24: want = 7'b0101_0_01;
        25: want = 7'b0100_0_01;
        40: want = 7'b0100_0_01;
        41: want = 7'b0000_0_01;
        48: want = 7'b0000_0_01;
        49: want = 7'b0000_1_10;
        default: begin want = 7'b0; have = 1'b0; end
      endcase
      if (have) begin
        if ({rst_out, ready, state} !== want) begin
          failures++;
          $display("FAIL soft_edge s=%0d got=%b exp=%b",
                   s, {rst_out, ready, state}, want);
        end
        checks++;
      end
      if ((rst_out & 4'b1010) !== 4'b0000) begin
        failures++;
        $display("FAIL soft_unmasked s=%0d got=%b exp=0000",
                 s, rst_out & 4'b1010);
      end
      checks++;
    end
  endtask

  task automatic test_ignored();
    do_reset();
    pll_lock = 1'b1;
    for (int i = 0; i < 55; i++) step();
    sw_rst_req = 1'b1;
    sw_rst_mask = 4'b0000;
    step();
    sw_rst_req = 1'b0;
    if ({rst_out, ready, state} !== 7'b0000_1_10) begin
      failures++;
      $display("FAIL ign_zero got=%b exp=%b",
               {rst_out, ready, state}, 7'b0000_1_10);
    end
    checks++;
    sw_rst_req = 1'b1;
    sw_rst_mask = 4'b1111;
    for (int s = 1; s <= 60; s++) begin
      step();
      sw_rst_req = (s == 18 || s == 30) ? 1'b1 : 1'b0;
      sw_rst_mask = 4'b1111;
      if ({rst_out, ready, state, lock_lost} !== exp_vec()) begin
        failures++;
        $display("FAIL ign_model s=%0d got=%b exp=%b",
                 s, {rst_out, ready, state, lock_lost}, exp_vec());
      end
      checks++;
      if (s == 19 && {rst_out, state} !== 6'b1111_01) begin
        failures++;
        $display("FAIL ign_rel got=%b exp=%b",
                 {rst_out, state}, 6'b1111_01);
      end
      if (s == 19) checks++;
      if (s == 49 && state !== 2'd2) begin
        failures++;
        $display("FAIL ign_run got=%0d exp=2", state);
      end
      if (s == 49) checks++;
    end
  endtask

  task automatic test_lock_loss();
    do_reset();
    pll_lock = 1'b1;
    for (int i = 0; i < 30; i++) step();
    pll_lock = 1'b0;
    for (int i = 0; i < 3; i++) step();
    if ({state, lock_lost} !== 3'b00_0) begin
      failures++;
      $display("FAIL loss_prerun got=%b exp=%b",
               {state, lock_lost}, 3'b00_0);
    end
    checks++;
    pll_lock = 1'b1;
    for (int i = 0; i < 55; i++) step();
    sw_rst_req = 1'b1;
    sw_rst_mask = 4'($urandom_range(15, 1));
    step();
    sw_rst_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    pll_lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if ({rst_out, ready, state, lock_lost} !== exp_vec()) begin
        failures++;
        $display("FAIL loss_soft_model got=%b exp=%b",
                 {rst_out, ready, state, lock_lost}, exp_vec());
      end
      checks++;
    end
    if ({rst_out, ready, state, lock_lost} !== 8'b1111_0_00_1) begin
      failures++;
      $display("FAIL loss_soft got=%b exp=%b",
               {rst_out, ready, state, lock_lost}, 8'b1111_0_00_1);
    end
    checks++;
    pll_lock = 1'b1;
    for (int i = 0; i < 60; i++) step();
    if ({ready, lock_lost} !== 2'b11) begin
      failures++;
      $display("FAIL loss_sticky got=%b exp=11", {ready, lock_lost});
    end
    checks++;
    lock_lost_clr = 1'b1;
    step();
    lock_lost_clr = 1'b0;
    if (lock_lost !== 1'b0) begin
      failures++;
      $display("FAIL loss_clr got=%b exp=0", lock_lost);
    end
    checks++;
    pll_lock = 1'b0;
    for (int i = 0; i < 3; i++) step();
    if ({rst_out, ready, state, lock_lost} !== 8'b1111_0_00_1) begin
      failures++;
      $display("FAIL loss_run got=%b exp=%b",
               {rst_out, ready, state, lock_lost}, 8'b1111_0_00_1);
    end
    checks++;
    pll_lock = 1'b1;
    for (int i = 0; i < 60; i++) step();
    lock_lost_clr = 1'b1;
    step();
    lock_lost_clr = 1'b0;
    pll_lock = 1'b0;
    step();
    step();
    lock_lost_clr = 1'b1;
    step();
    lock_lost_clr = 1'b0;
    if ({state, lock_lost} !== 3'b00_1) begin
      failures++;
      $display("FAIL loss_set_wins got=%b exp=%b",
               {state, lock_lost}, 3'b00_1);
    end
    checks++;
    if ({rst_out, ready, state, lock_lost} !== exp_vec()) begin
      failures++;
      $display("FAIL loss_end_model got=%b exp=%b",
               {rst_out, ready, state, lock_lost}, exp_vec());
    end
    checks++;
  endtask

  task automatic test_async_reset();
    do_reset();
    pll_lock = 1'b1;
    for (int i = 0; i < 55; i++) step();
    pll_lock = 1'b0;
    for (int i = 0; i < 4; i++) step();
    pll_lock = 1'b1;
    for (int i = 0; i < 35; i++) step();
    if ({rst_out, lock_lost} !== 5'b1100_1) begin
      failures++;
      $display("FAIL arst_pre got=%b exp=%b",
               {rst_out, lock_lost}, 5'b1100_1);
    end
    checks++;
    #2;
    rst = 1'b1;
    #1;
    if ({rst_out, ready, state, lock_lost} !== 8'b1111_0_00_0) begin
      failures++;
      $display("FAIL arst_now got=%b exp=%b",
               {rst_out, ready, state, lock_lost}, 8'b1111_0_00_0);
    end
    checks++;
    model_reset();
    step();
    rst = 1'b0;
    for (int e = 1; e <= 52; e++) begin
      step();
      if ({rst_out, ready, state, lock_lost} !== exp_vec()) begin
        failures++;
        $display("FAIL arst_model e=%0d got=%b exp=%b",
                 e, {rst_out, ready, state, lock_lost}, exp_vec());
      end
      checks++;
      if (e == 27 && rst_out !== 4'b1110) begin
        failures++;
        $display("FAIL arst_rel0 got=%b exp=1110", rst_out);
      end
      if (e == 27) checks++;
      if (e == 51 && {rst_out, ready} !== 5'b0000_1) begin
        failures++;
        $display("FAIL arst_ready got=%b exp=00001", {rst_out, ready});
      end
      if (e == 51) checks++;
    end
  endtask

  task automatic test_random();
    int drop_left;
    drop_left = 0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (drop_left > 0) begin
        pll_lock = 1'b0;
        drop_left--;
      end else begin
        pll_lock = 1'b1;
        if ($urandom_range(299) == 0)
          drop_left = $urandom_range(20, 1);
      end
      sw_rst_req = ($urandom_range(24) == 0);
      sw_rst_mask = 4'($urandom);
      lock_lost_clr = ($urandom_range(60) == 0);
      step();
      if ({rst_out, ready, state, lock_lost} !== exp_vec()) begin
        failures++;
        $display("FAIL rand_model c=%0d got=%b exp=%b",
                 c, {rst_out, ready, state, lock_lost}, exp_vec());
      end
      checks++;
    end
    sw_rst_req = 1'b0;
    lock_lost_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pll_lock = 1'b0;
    sw_rst_req = 1'b0;
    sw_rst_mask = 4'h0;
    lock_lost_clr = 1'b0;
    model_reset();
    test_reset();
    test_power_up();
    test_lock_filter();
    test_soft_reset();
    test_ignored();
    test_lock_loss();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Reset sequencer in the system clock domain, downstream of the PLL/reset generator.
- Waits for a stable, filtered PLL lock, then releases N per-subsystem resets one at a time in index order with a fixed gap (e.g. QPI memory, then SERDES sync, then core, then peripherals).
- Supports software soft-reset of a selectable subset of domains at runtime.
- On PLL lock loss, re-asserts every domain reset and restarts the sequence.

Parameters:
- N_DOMAINS, 4, number of sequenced reset outputs (1..8).
- LOCK_FILT, 16, consecutive synchronized lock=1 samples required before release (2..255).
- GAP_CYCLES, 8, clk cycles between successive domain releases (1..255).
- HOLD_CYCLES, 16, clk cycles soft-reset domains are held before re-release (1..255).

Ports:
- clk  in  1  system clock (all logic on posedge).
- rst  in  1  reset, asynchronous, active-high. Forces the reset state immediately.
- pll_lock  in  1  raw PLL lock, asynchronous to clk. Synchronized internally with a 2-flop synchronizer.
- sw_rst_req  in  1  single-cycle soft-reset request pulse.
- sw_rst_mask  in  N_DOMAINS  domains to soft-reset. Sampled only when sw_rst_req=1.
- lock_lost_clr  in  1  clears the lock_lost flag.
- rst_out  out  N_DOMAINS  per-domain resets, active-high, registered.
- ready  out  1  1 when all domains are released and the FSM is in RUN.
- lock_lost  out  1  sticky flag: lock dropped after the first RUN was reached.
- state  out  2  FSM state for debug: 0=HOLD, 1=REL, 2=RUN, 3=SOFT.

Behaviour:
- Reset values (rst=1): state=HOLD, rst_out=all ones, ready=0, lock_lost=0, sync flops=0, all counters=0, rel_set=all ones.
- lock_s is the 2-flop-synchronized pll_lock.
- lock_cnt:
  - increments (saturating at LOCK_FILT) on each edge where lock_s=1;
  - clears to 0 on any edge where lock_s=0.
- HOLD:
  - rst_out=all ones, ready=0.
  - When lock_cnt==LOCK_FILT: go to REL with idx=0, gap_cnt=0, rel_set=all ones.
- REL:
  - gap_cnt increments each cycle.
  - When gap_cnt==GAP_CYCLES-1: clear rst_out[idx] if rel_set[idx]=1, set idx=idx+1, set gap_cnt=0.
  - Domains with rel_set[idx]=0 still consume GAP_CYCLES; timing does not depend on the mask.
  - On the edge that handles idx==N_DOMAINS-1: go to RUN and set ready=1 on that same edge.
- RUN:
  - If sw_rst_req=1 and sw_rst_mask!=0: rst_out |= sw_rst_mask, rel_set=sw_rst_mask, ready=0, hold_cnt=0, go to SOFT.
  - Effect is visible on the next edge.
  - If sw_rst_mask==0: request ignored.
- SOFT:
  - hold_cnt increments each cycle.
  - When hold_cnt==HOLD_CYCLES-1: go to REL with idx=0, gap_cnt=0.
  - Unmasked domains stay deasserted throughout.
- sw_rst_req outside RUN is ignored and not queued.
- Lock loss: if lock_s=0 in REL, RUN or SOFT, the next edge forces HOLD, rst_out=all ones, ready=0, and discards idx and counters.
  - Lock loss has priority over sw_rst_req in the same cycle.
- lock_lost:
  - set on a lock-loss exit from RUN or SOFT, or from REL after the first RUN has been reached;
  - cleared by lock_lost_clr;
  - if set and clear occur in the same cycle, set wins.
- rst asserted mid-operation: immediate return to reset values, including clearing lock_lost.
- Glitch rule: every output is driven directly from a flop, never combinationally.
- Default-parameter timing, counted from the first clk edge sampling pll_lock=1 (2 sync + LOCK_FILT + 1 + GAP_CYCLES):
  - rst_out[0] falls 27 edges later;
  - rst_out[i] falls GAP_CYCLES edges after rst_out[i-1];
  - ready rises together with rst_out[3], at edge 51.

Test Plan:
- Power-up: rst pulse, then pll_lock=1 held → rst_out goes 1111→1110 at edge 27, →1100 at 35, →1000 at 43, →0000 with ready=1 at 51.
- Lock filter: pll_lock high for 10 cycles, low for 1, then high → no release until 16 consecutive lock_s=1 samples; rst_out[0] falls 27 edges after the final rise.
- Soft reset: in RUN, sw_rst_req with mask=4'b0101 → next edge rst_out=0101, ready=0. Held 16 cycles, then bit0 clears after 8 more cycles, bit2 after a further 16, ready=1 at 32 cycles after SOFT exit. Bits 1 and 3 stay 0 throughout.
- Ignored requests: sw_rst_req with mask=0 in RUN, and sw_rst_req during REL → no change to rst_out, ready or state.
- Lock loss: drop pll_lock during SOFT and again during RUN → within 3 edges rst_out=1111, ready=0, state=HOLD, lock_lost=1. lock_lost stays set through re-sequencing until lock_lost_clr is pulsed; a clear coinciding with a new loss leaves lock_lost=1.
- Async reset mid-REL (after rst_out=1100) → rst_out=1111, ready=0, lock_lost=0 immediately without a clock edge; re-sequence timing matches the power-up scenario.
